// File: rtl/mat_loader_pkg.sv
// Shared types and helpers for the matmul BRAM loader: FSM state encoding,
// target indices and the BRAM address-width calculation.
package mat_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_DONE,
    ST_WAIT_COMP
  } state_t;

  localparam int TGT_INPUT  = 0;
  localparam int TGT_WEIGHT = 1;

  // Words per core = ceil(rows*cols/cores); a one-word BRAM still needs one address bit.
  function automatic int calc_addr_width(input int rows, input int cols, input int cores);
    int words;
    words = (rows * cols + cores - 1) / cores;
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/mat_bram_loader_pair_writer.sv
// Turns accepted stream beats into BRAM port A/B writes: even beats are parked in a
// pair buffer and written together with the following odd beat, or alone on flush.
module bram_pair_writer
  import mat_loader_pkg::*;
#(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 6,
  parameter int NUM_TARGETS = 2,
  parameter int DUAL_PORT   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   beat_valid_i,
  input  logic [ADDR_WIDTH-1:0]  beat_idx_i,
  input  logic [DATA_WIDTH-1:0]  beat_data_i,
  input  logic [NUM_TARGETS-1:0] tgt_onehot_i,
  input  logic                   flush_i,
  output logic [NUM_TARGETS-1:0] ena_o,
  output logic                   wea_o,
  output logic [ADDR_WIDTH-1:0]  addra_o,
  output logic [DATA_WIDTH-1:0]  dina_o,
  output logic [NUM_TARGETS-1:0] enb_o,
  output logic                   web_o,
  output logic [ADDR_WIDTH-1:0]  addrb_o,
  output logic [DATA_WIDTH-1:0]  dinb_o
);

  logic [NUM_TARGETS-1:0] ena_q, enb_q;
  logic                   wea_q, web_q;
  logic [ADDR_WIDTH-1:0]  addra_q, addrb_q, buf_addr_q;
  logic [DATA_WIDTH-1:0]  dina_q, dinb_q, buf_data_q;
  logic                   pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ena_q      <= '0;
      enb_q      <= '0;
      wea_q      <= 1'b0;
      web_q      <= 1'b0;
      addra_q    <= '0;
      addrb_q    <= '0;
      dina_q     <= '0;
      dinb_q     <= '0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      ena_q <= '0;
      enb_q <= '0;
      wea_q <= 1'b0;
      web_q <= 1'b0;
      if (DUAL_PORT != 0) begin
        if (beat_valid_i && !beat_idx_i[0]) begin
          buf_data_q <= beat_data_i;
          buf_addr_q <= beat_idx_i;
          pend_q     <= 1'b1;
        end else if (beat_valid_i) begin
          ena_q   <= tgt_onehot_i;
          enb_q   <= tgt_onehot_i;
          wea_q   <= 1'b1;
          web_q   <= 1'b1;
          addra_q <= buf_addr_q;
          dina_q  <= buf_data_q;
          addrb_q <= beat_idx_i;
          dinb_q  <= beat_data_i;
          pend_q  <= 1'b0;
        end else if (flush_i && pend_q) begin
          // Odd-length tail: the parked even word goes out on port A alone.
          ena_q   <= tgt_onehot_i;
          wea_q   <= 1'b1;
          addra_q <= buf_addr_q;
          dina_q  <= buf_data_q;
          pend_q  <= 1'b0;
        end
      end else if (beat_valid_i) begin
        ena_q   <= tgt_onehot_i;
        wea_q   <= 1'b1;
        addra_q <= beat_idx_i;
        dina_q  <= beat_data_i;
      end
    end
  end

  assign ena_o   = ena_q;
  assign wea_o   = wea_q;
  assign addra_o = addra_q;
  assign dina_o  = dina_q;
  assign enb_o   = enb_q;
  assign web_o   = web_q;
  assign addrb_o = addrb_q;
  assign dinb_o  = dinb_q;

endmodule

// File: rtl/mat_bram_loader.sv
// Streaming loader feeding the matmul BRAMs: loads one target per request, tracks which
// targets hold data, and kicks the compute core once every target is loaded.
module mat_bram_loader
  import mat_loader_pkg::*;
#(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = calc_addr_width(8, 8, 1),
  parameter int NUM_TARGETS = 2,
  parameter int DUAL_PORT   = 1,
  parameter int AUTO_START  = 1,
  localparam int TSW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_req,
  input  logic [TSW-1:0]         target_sel,
  input  logic [ADDR_WIDTH:0]    word_count,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_last,
  output logic [NUM_TARGETS-1:0] bram_ena,
  output logic                   bram_wea,
  output logic [ADDR_WIDTH-1:0]  bram_addra,
  output logic [DATA_WIDTH-1:0]  bram_dina,
  output logic [NUM_TARGETS-1:0] bram_enb,
  output logic                   bram_web,
  output logic [ADDR_WIDTH-1:0]  bram_addrb,
  output logic [DATA_WIDTH-1:0]  bram_dinb,
  output logic                   busy,
  output logic                   load_done,
  output logic [NUM_TARGETS-1:0] loaded_mask,
  output logic                   start_out,
  input  logic                   compute_done,
  output logic                   err
);

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [TSW:0]        NT_LIMIT  = NUM_TARGETS[TSW:0];

  state_t                 state_q;
  logic [TSW-1:0]         tgt_q;
  logic [ADDR_WIDTH:0]    count_q, beat_q;
  logic                   early_q, err_q, load_done_q, start_q;
  logic [NUM_TARGETS-1:0] loaded_mask_q, mask_d, tgt_onehot;
  logic [ADDR_WIDTH:0]    beat_next;
  logic                   req_ok, beat_fire;

  for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_onehot
    assign tgt_onehot[gi] = (tgt_q == TSW'(gi));
  end

  assign req_ok    = (word_count != '0) && (word_count <= MAX_WORDS) &&
                     ({1'b0, target_sel} < NT_LIMIT);
  assign s_ready   = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign beat_fire = s_valid && s_ready;
  assign beat_next = beat_q + ONE;
  assign mask_d    = loaded_mask_q | tgt_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      tgt_q         <= '0;
      count_q       <= '0;
      beat_q        <= '0;
      early_q       <= 1'b0;
      err_q         <= 1'b0;
      loaded_mask_q <= '0;
      load_done_q   <= 1'b0;
      start_q       <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      start_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_req) begin
            if (req_ok) begin
              tgt_q   <= target_sel;
              count_q <= word_count;
              beat_q  <= '0;
              early_q <= 1'b0;
              err_q   <= 1'b0;
              state_q <= ST_LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (beat_fire) begin
            beat_q <= beat_next;
            if (beat_next == count_q) begin
              if (!s_last) err_q <= 1'b1;
              state_q <= ST_FLUSH;
            end else if (s_last) begin
              // Premature s_last: stop here and leave the target unmarked.
              err_q   <= 1'b1;
              early_q <= 1'b1;
              state_q <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          state_q <= ST_DONE;
          if (!early_q) begin
            loaded_mask_q <= mask_d;
            load_done_q   <= 1'b1;
            start_q       <= (AUTO_START != 0) && (&mask_d);
          end
        end
        ST_DONE: begin
          state_q <= start_q ? ST_WAIT_COMP : ST_IDLE;
        end
        ST_WAIT_COMP: begin
          if (compute_done) begin
            loaded_mask_q <= '0;
            state_q       <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign err         = err_q;
  assign load_done   = load_done_q;
  assign start_out   = start_q;
  assign loaded_mask = loaded_mask_q;

  bram_pair_writer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_TARGETS(NUM_TARGETS),
    .DUAL_PORT  (DUAL_PORT)
  ) u_writer (
    .clk         (clk),
    .rst_n       (rst_n),
    .beat_valid_i(beat_fire),
    .beat_idx_i  (beat_q[ADDR_WIDTH-1:0]),
    .beat_data_i (s_data),
    .tgt_onehot_i(tgt_onehot),
    .flush_i     (state_q == ST_FLUSH),
    .ena_o       (bram_ena),
    .wea_o       (bram_wea),
    .addra_o     (bram_addra),
    .dina_o      (bram_dina),
    .enb_o       (bram_enb),
    .web_o       (bram_web),
    .addrb_o     (bram_addrb),
    .dinb_o      (bram_dinb)
  );

endmodule

// File: tb/tb_mat_bram_loader.sv
// Directed bench for mat_bram_loader: a dual-port auto-start instance and a
// single-port instance share the stream inputs; all BRAM writes are logged and compared.
module tb_mat_bram_loader;
  import mat_loader_pkg::*;

  localparam int DW = 128;
  localparam int AW = calc_addr_width(8, 8, 1);
  localparam int NT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_req, load_req2;
  logic [0:0]    target_sel;
  logic [AW:0]   word_count;
  logic          s_valid, s_last, compute_done;
  logic [DW-1:0] s_data;

  logic          s_ready, busy, load_done, start_out, err, wea, web;
  logic [NT-1:0] ena, enb, loaded_mask;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, dinb;

  logic          s_ready2, busy2, load_done2, start_out2, err2, wea2, web2;
  logic [NT-1:0] ena2, enb2, loaded_mask2;
  logic [AW-1:0] addra2, addrb2;
  logic [DW-1:0] dina2, dinb2;

  typedef struct packed {
    logic [NT-1:0] ena, enb;
    logic          wea, web;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dina, dinb;
  } wr_t;

  wr_t wq[$];
  wr_t wq2[$];
  int  checks = 0, errors = 0;
  int  ld_cnt = 0, st_cnt = 0;
  logic [NT-1:0] ld_mask;
  logic          ld_start;
  bit            enb2_seen = 1'b0;

  always #5 clk = ~clk;

  mat_bram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TARGETS(NT),
                    .DUAL_PORT(1), .AUTO_START(1)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .target_sel(target_sel),
    .word_count(word_count), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .bram_ena(ena), .bram_wea(wea), .bram_addra(addra), .bram_dina(dina),
    .bram_enb(enb), .bram_web(web), .bram_addrb(addrb), .bram_dinb(dinb), .busy(busy),
    .load_done(load_done), .loaded_mask(loaded_mask), .start_out(start_out),
    .compute_done(compute_done), .err(err)
  );

  mat_bram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TARGETS(NT),
                    .DUAL_PORT(0), .AUTO_START(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_req(load_req2), .target_sel(target_sel),
    .word_count(word_count), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
    .s_last(s_last), .bram_ena(ena2), .bram_wea(wea2), .bram_addra(addra2), .bram_dina(dina2),
    .bram_enb(enb2), .bram_web(web2), .bram_addrb(addrb2), .bram_dinb(dinb2), .busy(busy2),
    .load_done(load_done2), .loaded_mask(loaded_mask2), .start_out(start_out2),
    .compute_done(compute_done), .err(err2)
  );

  always @(negedge clk) begin
    if (ena != '0 || enb != '0)
      wq.push_back('{ena, enb, wea, web, addra, addrb, dina, dinb});
    if (ena2 != '0 || enb2 != '0)
      wq2.push_back('{ena2, enb2, wea2, web2, addra2, addrb2, dina2, dinb2});
    if (enb2 != '0) enb2_seen = 1'b1;
    if (load_done) begin
      ld_cnt++;
      ld_mask  = loaded_mask;
      ld_start = start_out;
    end
    if (start_out) st_cnt++;
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkd(input logic [31:0] base, input int i);
    return {base, 32'(i), ~32'(i), base ^ 32'(i)};
  endfunction

  task automatic do_req(input bit sel, input int tgt, input int wc);
    @(negedge clk);
    target_sel = 1'(tgt);
    word_count = (AW + 1)'(wc);
    if (sel) load_req2 = 1'b1; else load_req = 1'b1;
    @(negedge clk);
    load_req  = 1'b0;
    load_req2 = 1'b0;
    $display("req dut%0d tgt=%0d wc=%0d", sel ? 2 : 1, tgt, wc);
  endtask

  task automatic stream(input bit sel, input int n, input int last_at,
                        input logic [31:0] base, input bit rnd);
    int  i = 0;
    int  guard = 0;
    bit  fire;
    while (i < n && guard < 500) begin
      @(negedge clk);
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = mkd(base, i);
      s_last  = (i == last_at);
      fire    = s_valid && (sel ? s_ready2 : s_ready);
      @(posedge clk);
      if (fire) i++;
      guard++;
    end
    chk("stream_beats", i, n);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Expected dual-port trace: pairs (2k,2k+1) on A/B, an odd tail on A only.
  task automatic chk_dp(input int tgt, input int n, input logic [31:0] base);
    logic [NT-1:0] oh;
    int            nexp;
    oh   = NT'(1) << tgt;
    nexp = (n + 1) / 2;
    chk("dp_nwrites", wq.size(), nexp);
    for (int k = 0; k < nexp && k < wq.size(); k++) begin
      chk("dp_ena", wq[k].ena, oh);
      chk("dp_wea", wq[k].wea, 1);
      chk("dp_addra", wq[k].addra, 2 * k);
      chk("dp_dina", wq[k].dina, mkd(base, 2 * k));
      if (2 * k + 1 < n) begin
        chk("dp_enb", wq[k].enb, oh);
        chk("dp_web", wq[k].web, 1);
        chk("dp_addrb", wq[k].addrb, 2 * k + 1);
        chk("dp_dinb", wq[k].dinb, mkd(base, 2 * k + 1));
      end else begin
        chk("dp_tail_enb", wq[k].enb, 0);
      end
    end
  endtask

  task automatic clear_log();
    wq.delete();
    wq2.delete();
    ld_cnt = 0;
    st_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; load_req = 1'b0; load_req2 = 1'b0; target_sel = '0; word_count = '0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; compute_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_mask", loaded_mask, 0);
    chk("rst_en", {ena, enb, wea, web}, 0);
    chk("rst_addr_data", {addra, addrb, dina}, 0);
    chk("rst_pulses", {load_done, start_out}, 0);
    rst_n = 1'b1;

    // Input matrix, 8 words, even/odd pairs.
    clear_log();
    do_req(0, TGT_INPUT, 8);
    stream(0, 8, 7, 32'hA000_0000, 0);
    repeat (4) @(negedge clk);
    chk_dp(TGT_INPUT, 8, 32'hA000_0000);
    chk("s1_ld_cnt", ld_cnt, 1);
    chk("s1_mask", ld_mask, 2'b01);
    chk("s1_no_start", st_cnt, 0);
    chk("s1_idle", busy, 0);

    // Weight matrix, 5 words: odd tail, then auto-start.
    clear_log();
    do_req(0, TGT_WEIGHT, 5);
    stream(0, 5, 4, 32'hB000_0000, 0);
    repeat (4) @(negedge clk);
    chk_dp(TGT_WEIGHT, 5, 32'hB000_0000);
    chk("s2_ld_cnt", ld_cnt, 1);
    chk("s2_mask", ld_mask, 2'b11);
    chk("s2_start_cnt", st_cnt, 1);
    chk("s2_start_with_done", ld_start, 1);
    chk("s2_busy_wait", busy, 1);
    do_req(0, TGT_INPUT, 8);
    repeat (3) @(negedge clk);
    chk("s2_req_ignored", {busy, s_ready}, 2'b10);
    chk("s2_mask_hold", loaded_mask, 2'b11);
    compute_done = 1'b1;
    @(negedge clk);
    compute_done = 1'b0;
    chk("s2_cd_busy", busy, 0);
    chk("s2_cd_mask", loaded_mask, 0);

    // Random valid gaps on an 8-word load.
    clear_log();
    do_req(0, TGT_INPUT, 8);
    stream(0, 8, 7, 32'hC000_0000, 1);
    repeat (4) @(negedge clk);
    chk_dp(TGT_INPUT, 8, 32'hC000_0000);
    chk("s3_ld_cnt", ld_cnt, 1);
    chk("s3_mask", loaded_mask, 2'b01);
    chk("s3_err", err, 0);

    // Premature s_last on beat 3.
    clear_log();
    do_req(0, TGT_WEIGHT, 8);
    stream(0, 4, 3, 32'hE000_0000, 0);
    repeat (4) @(negedge clk);
    chk("s4_err", err, 1);
    chk("s4_mask", loaded_mask, 2'b01);
    chk("s4_no_done", ld_cnt, 0);
    chk("s4_idle", {busy, s_ready}, 0);

    // Reset in the middle of a load, then a clean reload.
    do_req(0, TGT_INPUT, 8);
    stream(0, 5, -1, 32'hF000_0000, 0);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_busy", {busy, s_ready}, 0);
    chk("s5_rst_en", {ena, enb, wea, web}, 0);
    chk("s5_rst_addr_data", {addra, addrb, dina}, 0);
    chk("s5_rst_mask_err", {loaded_mask, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    do_req(0, TGT_INPUT, 8);
    stream(0, 8, 7, 32'h1234_0000, 0);
    repeat (4) @(negedge clk);
    chk_dp(TGT_INPUT, 8, 32'h1234_0000);
    chk("s5_err", err, 0);
    chk("s5_mask", loaded_mask, 2'b01);
    chk("s5_ld_cnt", ld_cnt, 1);

    // Zero-length request is rejected.
    clear_log();
    do_req(0, TGT_INPUT, 0);
    repeat (3) @(negedge clk);
    chk("s6_err", err, 1);
    chk("s6_busy", busy, 0);
    chk("s6_no_writes", wq.size(), 0);

    // Single-port instance: oversize request rejected, then a 3-word load on port A.
    clear_log();
    do_req(1, TGT_INPUT, 65);
    repeat (3) @(negedge clk);
    chk("s7_err65", err2, 1);
    chk("s7_busy65", busy2, 0);
    chk("s7_no_writes", wq2.size(), 0);
    do_req(1, TGT_INPUT, 3);
    stream(1, 3, 2, 32'h5500_0000, 0);
    repeat (4) @(negedge clk);
    chk("s7_nwrites", wq2.size(), 3);
    for (int k = 0; k < 3 && k < wq2.size(); k++) begin
      chk("s7_ena", wq2[k].ena, 2'b01);
      chk("s7_addra", wq2[k].addra, k);
      chk("s7_dina", wq2[k].dina, mkd(32'h5500_0000, k));
    end
    chk("s7_enb_never", enb2_seen, 0);
    chk("s7_err", err2, 0);
    chk("s7_mask", loaded_mask2, 2'b01);
    chk("s7_no_start", start_out2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
